fpga_input_ctrl: RTL and testbench

- Board-input front end for the pipelined CPU, opposite direction to the HEX/LEDR display interface.
- Synchronizes SW[9:0] and debounces KEY[1:0] (active-low DE1-SoC push buttons).
- Produces the CPU step enable for manual-clock and free-run modes, a soft-reset level, and registered mode/select outputs.
- Emits a one-cycle select_changed pulse so the display side can blank on a selection change.

---
 rtl/fpga_input_ctrl.sv | 229 ++++++++++++++++++++++
 tb/tb_fpga_input_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_input_ctrl.sv
// Board-input front end: synchronizes SW, debounces KEY, drives CPU step enable / soft reset.
// Latency: SW to outputs 2 cycles; clean KEY[0] press to cpu_step_en 2 + DEBOUNCE_CYCLES + 1 cycles.
// Backpressure: none; inputs are free-running and every pulse is a single, unqueued cycle.
// Optional feature: define FPGA_INPUT_AUTO_REPEAT_EN for held-key auto-repeat in manual mode.
module fpga_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int RUN_DIV         = 4,
  parameter int REPEAT_DELAY    = 500000,
  parameter int REPEAT_PERIOD   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic       cpu_step_en,
  output logic       cpu_soft_rst,
  output logic       is_manual_clk_mode,
  output logic       is_show_reg_mode,
  output logic [3:0] reg_select,
  output logic [2:0] stage_select,
  output logic       select_changed
);

  // Debounce counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int                DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_ONE  = DB_W'(1);

  // Free-run divider; keep at least one bit so RUN_DIV=1 still elaborates.
  localparam int                DIV_W    = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [DIV_W-1:0]  DIV_ONE  = DIV_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_HELD = 2'd2
  } step_state_t;

  // Switch synchronizer. SW[3] has no function, so only 9 bits are carried:
  // [8] = SW[9] mode, [7] = SW[8] show-reg, [6:3] = SW[7:4], [2:0] = SW[2:0].
  logic [8:0] sw_s1;
  logic [8:0] sw_s2;
  logic       sel_chg;
  logic       sw3_unused;

  // Key path: synchronized (pressed = 1), debounced level, per-key stability counter.
  logic [1:0]      key_s1;
  logic [1:0]      key_s2;
  logic [1:0]      key_db;
  logic [DB_W-1:0] db_cnt [2];

  // Mode tracking and free-run divider.
  logic             mode;
  logic             mode_prev;
  logic             mode_chg;
  logic [DIV_W-1:0] div_cnt;

  // Step FSM.
  step_state_t state;
  step_state_t state_nxt;
  logic        fire_pulse;
  logic        step_manual;

  assign sw3_unused = SW[3];

  // Two-flop SW synchronizer; select_changed is the registered s1/s2 difference
  // so it rises in the same cycle the new value reaches the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      sel_chg <= 1'b0;
    end else begin
      sw_s1   <= {SW[9:4], SW[2:0]};
      sw_s2   <= sw_s1;
      sel_chg <= (sw_s1[7:0] != sw_s2[7:0]);
    end
  end

  assign is_manual_clk_mode = sw_s2[8];
  assign is_show_reg_mode   = sw_s2[7];
  assign reg_select         = sw_s2[6:3];
  assign stage_select       = sw_s2[2:0];
  assign select_changed     = sel_chg;

  // Key synchronizer and debouncer: a level must differ from the accepted
  // state for DEBOUNCE_CYCLES consecutive cycles before it is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_s1 <= '0;
      key_s2 <= '0;
      key_db <= '0;
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      key_s1 <= ~KEY;
      key_s2 <= key_s1;
      for (int i = 0; i < 2; i++) begin
        if (key_s2[i] != key_db[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            key_db[i] <= key_s2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DB_ONE;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  assign cpu_soft_rst = key_db[1];

  assign mode     = sw_s2[8];
  assign mode_chg = mode ^ mode_prev;

  // Mode history and free-run divider; the divider restarts on any mode flip
  // and idles at zero in manual mode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_prev <= 1'b0;
      div_cnt   <= '0;
    end else begin
      mode_prev <= mode;
      if (mode_chg || mode) begin
        div_cnt <= '0;
      end else if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + DIV_ONE;
      end
    end
  end

  // Step FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Step FSM next state: a press always moves the FSM out of IDLE so a held key
  // is tracked in every mode, but only a manual-mode press routes through FIRE.
  always_comb begin
    state_nxt  = state;
    fire_pulse = 1'b0;
    case (state)
      S_IDLE: begin
        if (key_db[0]) begin
          state_nxt = (mode && !mode_chg) ? S_FIRE : S_HELD;
        end
      end
      S_FIRE: begin
        fire_pulse = mode && !mode_chg;
        state_nxt  = S_HELD;
      end
      S_HELD: begin
        if (!key_db[0]) begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

`ifdef FPGA_INPUT_AUTO_REPEAT_EN
  localparam int               RPT_MAX      = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int               RPT_W        = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY_V  = RPT_W'(REPEAT_DELAY);
  localparam logic [RPT_W-1:0] RPT_PERIOD_V = RPT_W'(REPEAT_PERIOD);
  localparam logic [RPT_W-1:0] RPT_ONE      = RPT_W'(1);

  // rpt_cnt holds cycles since FIRE (delay phase) or since the last repeat
  // (periodic phase); repeats are armed only by a real manual-mode FIRE.
  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_armed;
  logic             rpt_periodic;
  logic             rpt_hit;

  assign rpt_hit = (state == S_HELD) && rpt_armed && key_db[0] && mode && !mode_chg &&
                   (rpt_cnt == (rpt_periodic ? RPT_PERIOD_V : RPT_DELAY_V));

  // Repeat timer: cleared on release or any mode change, re-armed by FIRE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt      <= '0;
      rpt_armed    <= 1'b0;
      rpt_periodic <= 1'b0;
    end else if (mode_chg || !mode || !key_db[0]) begin
      rpt_cnt      <= '0;
      rpt_armed    <= 1'b0;
      rpt_periodic <= 1'b0;
    end else if (fire_pulse) begin
      rpt_cnt      <= RPT_ONE;
      rpt_armed    <= 1'b1;
      rpt_periodic <= 1'b0;
    end else if ((state == S_HELD) && rpt_armed) begin
      if (rpt_hit) begin
        rpt_cnt      <= RPT_ONE;
        rpt_periodic <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + RPT_ONE;
      end
    end else begin
      rpt_cnt      <= '0;
      rpt_armed    <= 1'b0;
      rpt_periodic <= 1'b0;
    end
  end

  assign step_manual = fire_pulse | rpt_hit;
`else
  logic rpt_params_unused;
  assign rpt_params_unused = (REPEAT_DELAY != 0) ^ (REPEAT_PERIOD != 0);
  assign step_manual       = fire_pulse;
`endif

  // Step enable: manual pulses or the divider tap, never in a mode-change cycle
  // and never while reset is held.
  assign cpu_step_en = !rst && !mode_chg && (mode ? step_manual : (div_cnt == DIV_LAST));

endmodule

// File: tb/tb_fpga_input_ctrl.sv
module tb_fpga_input_ctrl;

  localparam int DB = 4;
  localparam int RD = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] KEY;
  logic [9:0] SW;
  logic       cpu_step_en;
  logic       cpu_soft_rst;
  logic       is_manual_clk_mode;
  logic       is_show_reg_mode;
  logic [3:0] reg_select;
  logic [2:0] stage_select;
  logic       select_changed;

  fpga_input_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .RUN_DIV(4),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .KEY(KEY),
    .SW(SW),
    .cpu_step_en(cpu_step_en),
    .cpu_soft_rst(cpu_soft_rst),
    .is_manual_clk_mode(is_manual_clk_mode),
    .is_show_reg_mode(is_show_reg_mode),
    .reg_select(reg_select),
    .stage_select(stage_select),
    .select_changed(select_changed)
  );

  always #5 clk = ~clk;

  int cyc    = 0;
  int n_vec  = 0;
  int n_err  = 0;
  bit chk_en = 1'b0;
  int exp_q[$];

  typedef struct {
    logic [9:0] sw;
    logic [9:0] exp;   // {mode, show, reg[3:0], stage[2:0], select_changed}
  } sw_vec_t;

  sw_vec_t vecs [9];

  always @(posedge clk) cyc <= cyc + 1;

  // Step-pulse scoreboard: every cpu_step_en must match the head of exp_q.
  always @(posedge clk) begin
    #1;
    if (chk_en && !rst) begin
      while (exp_q.size() > 0 && exp_q[0] < cyc) begin
        n_vec++;
        n_err++;
        $display("FAIL step_pulse: missing pulse expected at cycle %0d (now %0d)", exp_q[0], cyc);
        void'(exp_q.pop_front());
      end
      if (cpu_step_en) begin
        n_vec++;
        if (exp_q.size() > 0 && exp_q[0] == cyc) begin
          void'(exp_q.pop_front());
        end else begin
          n_err++;
          $display("FAIL step_pulse: pulse at cycle %0d, next expected %0d", cyc,
                   (exp_q.size() > 0) ? exp_q[0] : -1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [11:0] outs();
    return {cpu_step_en, cpu_soft_rst, is_manual_clk_mode, is_show_reg_mode,
            reg_select, stage_select, select_changed};
  endfunction

  function automatic logic [9:0] sw_outs();
    return {is_manual_clk_mode, is_show_reg_mode, reg_select, stage_select, select_changed};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press KEY[0] for 'hold' cycles, queue the expected pulses, release and settle.
  task automatic press_hold(input int hold);
    int f;
    KEY[0] = 1'b0;
    f = cyc + 2 + DB + 1;
    exp_q.push_back(f);
`ifdef FPGA_INPUT_AUTO_REPEAT_EN
    begin
      int rel;
      rel = cyc + hold + 2 + DB;
      for (int t = f + RD; t < rel; t += RP) exp_q.push_back(t);
    end
`endif
    tick(hold);
    KEY[0] = 1'b1;
    tick(2 + DB + 4);
  endtask

  initial begin
    logic [9:0] prev;
    int r;

    vecs[0] = '{10'b1_1_0101_0_011, {1'b1, 1'b1, 4'd5,  3'd3, 1'b1}};
    vecs[1] = '{10'b1_1_0101_1_011, {1'b1, 1'b1, 4'd5,  3'd3, 1'b0}};
    vecs[2] = '{10'b1_0_0101_1_011, {1'b1, 1'b0, 4'd5,  3'd3, 1'b1}};
    vecs[3] = '{10'b1_0_1010_1_011, {1'b1, 1'b0, 4'd10, 3'd3, 1'b1}};
    vecs[4] = '{10'b1_0_1010_1_100, {1'b1, 1'b0, 4'd10, 3'd4, 1'b1}};
    vecs[5] = '{10'b0_0_1010_1_100, {1'b0, 1'b0, 4'd10, 3'd4, 1'b0}};
    vecs[6] = '{10'b1_0_1010_1_100, {1'b1, 1'b0, 4'd10, 3'd4, 1'b0}};
    vecs[7] = '{10'b1_1_1111_0_111, {1'b1, 1'b1, 4'd15, 3'd7, 1'b1}};
    vecs[8] = '{10'b1_0_0000_0_000, {1'b1, 1'b0, 4'd0,  3'd0, 1'b1}};

    rst = 1'b1;
    KEY = 2'b11;
    SW  = '0;
    tick(3);
    check("reset_outs", outs(), 12'h000);
    rst = 1'b0;
    tick(3);

    // Switch path: old value after 1 edge, new value + pulse after 2, pulse gone after 3.
    prev = '0;
    for (int i = 0; i < 9; i++) begin
      SW = vecs[i].sw;
      tick(1);
      check($sformatf("sw%0d_edge1", i), sw_outs(), {prev[9:1], 1'b0});
      tick(1);
      check($sformatf("sw%0d_edge2", i), sw_outs(), vecs[i].exp);
      tick(1);
      check($sformatf("sw%0d_edge3", i), sw_outs(), {vecs[i].exp[9:1], 1'b0});
      prev = vecs[i].exp;
    end

    // Manual mode: one pulse per press regardless of hold length.
    tick(4);
    chk_en = 1'b1;
    press_hold(20);
    press_hold(10);
    press_hold(30);

    // Soft reset follows debounced KEY[1] and does not gate stepping.
    KEY[1] = 1'b0;
    tick(DB + 1);
    check("soft_rst_before_db", cpu_soft_rst, 1'b0);
    tick(1);
    check("soft_rst_pressed", cpu_soft_rst, 1'b1);
    press_hold(8);
    KEY[1] = 1'b1;
    tick(DB + 1);
    check("soft_rst_release_db", cpu_soft_rst, 1'b1);
    tick(1);
    check("soft_rst_released", cpu_soft_rst, 1'b0);

    // Bounce shorter than the debounce window on both keys: nothing happens.
    for (int i = 0; i < 4; i++) begin
      KEY = 2'b00;
      tick(2);
      KEY = 2'b11;
      tick(2);
    end
    tick(10);
    check("bounce_soft_rst", cpu_soft_rst, 1'b0);

    // Free-run from reset: pulses at 3, 7, 11, 15; held key adds nothing;
    // switching to manual with the key held gives no pulse until re-press.
    rst = 1'b1;
    SW  = '0;
    tick(2);
    check("reset_free_outs", outs(), 12'h000);
    rst = 1'b0;
    r = cyc;
    exp_q.push_back(r + 3);
    exp_q.push_back(r + 7);
    exp_q.push_back(r + 11);
    exp_q.push_back(r + 15);
    tick(1);
    KEY[0] = 1'b0;
    tick(15);
    SW[9] = 1'b1;
    tick(12);
    check("manual_held_mode", is_manual_clk_mode, 1'b1);
    KEY[0] = 1'b1;
    tick(10);
    press_hold(8);

    // Reset mid-debounce (counter = 2): outputs clear without a clock edge.
    SW = 10'b1_1_0101_0_011;
    tick(6);
    KEY[0] = 1'b0;
    tick(4);
    check("pre_rst_outs", outs(), {1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 3'd3, 1'b0});
    rst = 1'b1;
    #1;
    check("async_rst_debounce", outs(), 12'h000);
    tick(2);

    // Key still held after reset: seen as a fresh press after 2+DB+1 cycles.
    rst = 1'b0;
    KEY[1] = 1'b0;
    r = cyc;
    exp_q.push_back(r + 2 + DB + 1);
    tick(12);
    check("held_outs", outs(), {1'b0, 1'b1, 1'b1, 1'b1, 4'd5, 3'd3, 1'b0});
    rst = 1'b1;
    #1;
    check("async_rst_held", outs(), 12'h000);
    KEY = 2'b11;
    tick(3);
    rst = 1'b0;
    tick(12);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL pending_pulses: got %0d left want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
